onn_phase_monitor: RTL and testbench

ONN_PHASE_MONITOR -- requirements
Module: onn_phase_monitor

---
 rtl/onn_pkg.sv | 21 ++
 rtl/onn_phase_latch.sv | 49 ++++
 rtl/onn_phase_monitor.sv | 185 ++++++++++++++++++
 tb/tb_onn_phase_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onn_pkg.sv
// Shared constants and FSM encoding for the ONN phase monitor.
// ONN_PHASE_TOL_EN: when defined, a phase may drift by one count and still be "unchanged".
package onn_pkg;

  localparam int N_OSC   = 15;
  localparam int PHASE_W = 4;

`ifdef ONN_PHASE_TOL_EN
  localparam int PHASE_TOL = 1;
`else
  localparam int PHASE_TOL = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_STREAM
  } state_t;

endpackage

// File: rtl/onn_phase_latch.sv
// One oscillator's rising-edge detector: captures the shared phase count on its edge
// and remembers that an edge was seen since the last compare.
module onn_phase_latch
  import onn_pkg::*;
#(
  parameter int PHASE_W = onn_pkg::PHASE_W
) (
  input  logic               i_sclk,
  input  logic               i_rst_n,
  input  logic               i_osc,
  input  logic               i_en,
  input  logic [PHASE_W-1:0] i_cnt,
  input  logic               i_drop,
  input  logic               i_clr_seen,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_seen
);

  logic               r_osc_d;
  logic [PHASE_W-1:0] r_phase;
  logic               r_seen;
  logic               w_rise;

  assign w_rise = i_osc & ~r_osc_d;

  // Drop outranks a simultaneous edge so a discarded measurement never leaks through.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_osc_d <= 1'b0;
      r_phase <= '0;
      r_seen  <= 1'b0;
    end else begin
      r_osc_d <= i_osc;
      if (i_drop) begin
        r_phase <= '0;
        r_seen  <= 1'b0;
      end else if (i_clr_seen) begin
        r_seen  <= 1'b0;
      end else if (i_en && w_rise) begin
        r_phase <= i_cnt;
        r_seen  <= 1'b1;
      end
    end
  end

  assign o_phase = r_phase;
  assign o_seen  = r_seen;

endmodule

// File: rtl/onn_phase_monitor.sv
// Measures each oscillator's phase against osc_in[0], flags changes on compare and streams
// the stored phases out. Optional macro ONN_PHASE_TOL_EN widens the match tolerance to 1.
module onn_phase_monitor
  import onn_pkg::*;
#(
  parameter int N_OSC   = onn_pkg::N_OSC,
  parameter int PHASE_W = onn_pkg::PHASE_W
) (
  input  logic               sclk,
  input  logic               re_n,
  input  logic [N_OSC-1:0]   osc_in,
  input  logic               full_tick,
  input  logic               drop,
  input  logic               state_cheak,
  input  logic               phi_to_no,
  output logic [N_OSC-1:0]   state_changed,
  output logic               cmp_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_idx,
  output logic [PHASE_W-1:0] out_phase,
  output logic               out_last
);

  localparam logic [PHASE_W:0] L_PERIOD   = {1'b1, {PHASE_W{1'b0}}};
  localparam logic [PHASE_W:0] L_TOL      = (PHASE_W+1)'(PHASE_TOL);
  localparam logic [3:0]       L_LAST_IDX = 4'(N_OSC-1);

  logic [1:0]               r_rst_sync;
  logic                     w_rst_n;
  state_t                   r_state, w_state_next;
  logic [PHASE_W-1:0]       r_cnt, w_cnt_next;
  logic                     r_ref_d, r_cheak_d, r_phi_d;
  logic                     r_seen0, r_cmp_pend;
  logic                     w_ref_rise, w_cheak_rise, w_phi_rise;
  logic                     w_measure, w_compare, w_stream_start, w_beat;
  logic [N_OSC*PHASE_W-1:0] w_cur_phase, r_prev_phase;
  logic [N_OSC-1:0]         w_seen, w_changed, r_state_changed;
  logic                     r_cmp_done, r_out_valid, r_out_last;
  logic [3:0]               r_out_idx, w_idx_inc;
  logic [PHASE_W-1:0]       r_out_phase, w_next_phase;

  function automatic logic [PHASE_W:0] circ_dist(input logic [PHASE_W-1:0] a,
                                                 input logic [PHASE_W-1:0] b);
    logic [PHASE_W:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return (d > (L_PERIOD - d)) ? (L_PERIOD - d) : d;
  endfunction

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) r_rst_sync <= 2'b00;
    else       r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_ref_rise     = osc_in[0] & ~r_ref_d;
  assign w_cheak_rise   = state_cheak & ~r_cheak_d;
  assign w_phi_rise     = phi_to_no & ~r_phi_d;
  assign w_measure      = (r_state == ST_MEASURE);
  assign w_compare      = (r_state == ST_COMPARE);
  assign w_stream_start = (r_state == ST_IDLE) && (w_state_next == ST_STREAM);
  assign w_beat         = (r_state == ST_STREAM) && r_out_valid && out_ready;
  assign w_cnt_next     = w_ref_rise ? '0 : r_cnt + 1'b1;
  assign w_idx_inc      = r_out_idx + 4'd1;

  assign w_cur_phase[PHASE_W-1:0] = '0;
  assign w_seen[0]                = r_seen0;

  generate
    for (genvar gi = 1; gi < N_OSC; gi++) begin : g_latch
      onn_phase_latch #(.PHASE_W(PHASE_W)) u_latch (
        .i_sclk     (sclk),
        .i_rst_n    (w_rst_n),
        .i_osc      (osc_in[gi]),
        .i_en       (w_measure),
        .i_cnt      (w_cnt_next),
        .i_drop     (drop),
        .i_clr_seen (w_compare),
        .o_phase    (w_cur_phase[gi*PHASE_W +: PHASE_W]),
        .o_seen     (w_seen[gi])
      );
    end
    for (genvar gi = 0; gi < N_OSC; gi++) begin : g_cmp
      assign w_changed[gi] = ~w_seen[gi] |
        (circ_dist(w_cur_phase[gi*PHASE_W +: PHASE_W], r_prev_phase[gi*PHASE_W +: PHASE_W]) > L_TOL);
    end
  endgenerate

  always_comb begin
    w_next_phase = '0;
    for (int i = 0; i < N_OSC; i++) begin
      if (4'(i) == w_idx_inc) w_next_phase = r_prev_phase[i*PHASE_W +: PHASE_W];
    end
  end

  always_ff @(posedge sclk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // A compare held off by a stream is serviced first on return to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_cmp_pend || w_cheak_rise) w_state_next = ST_COMPARE;
        else if (w_phi_rise)            w_state_next = ST_STREAM;
        else if (full_tick)             w_state_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_cheak_rise)    w_state_next = ST_COMPARE;
        else if (!full_tick) w_state_next = ST_IDLE;
      end
      ST_COMPARE: w_state_next = ST_IDLE;
      ST_STREAM:  if (w_beat && r_out_last) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt      <= '0;
      r_ref_d    <= 1'b0;
      r_cheak_d  <= 1'b0;
      r_phi_d    <= 1'b0;
      r_seen0    <= 1'b0;
      r_cmp_pend <= 1'b0;
    end else begin
      r_ref_d   <= osc_in[0];
      r_cheak_d <= state_cheak;
      r_phi_d   <= phi_to_no;
      if (w_measure) r_cnt <= w_cnt_next;
      if (drop)                        r_seen0 <= 1'b0;
      else if (w_compare)              r_seen0 <= 1'b0;
      else if (w_measure && w_ref_rise) r_seen0 <= 1'b1;
      if ((r_state == ST_STREAM) && w_cheak_rise) r_cmp_pend <= 1'b1;
      else if (w_compare)                         r_cmp_pend <= 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state_changed <= '1;
      r_prev_phase    <= '0;
      r_cmp_done      <= 1'b0;
    end else begin
      r_cmp_done <= w_compare;
      if (w_compare) begin
        r_state_changed <= w_changed;
        r_prev_phase    <= w_cur_phase;
      end
    end
  end

  always_ff @(posedge sclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_phase <= '0;
      r_out_last  <= 1'b0;
    end else if (w_stream_start) begin
      r_out_valid <= 1'b1;
      r_out_idx   <= '0;
      r_out_phase <= r_prev_phase[PHASE_W-1:0];
      r_out_last  <= (N_OSC == 1);
    end else if (w_beat) begin
      if (r_out_last) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_idx   <= w_idx_inc;
        r_out_phase <= w_next_phase;
        r_out_last  <= (w_idx_inc == L_LAST_IDX);
      end
    end
  end

  assign state_changed = r_state_changed;
  assign cmp_done      = r_cmp_done;
  assign out_valid     = r_out_valid;
  assign out_idx       = r_out_idx;
  assign out_phase     = r_out_phase;
  assign out_last      = r_out_last;

endmodule

// File: tb/tb_onn_phase_monitor.sv
// Bench for onn_phase_monitor: table of measurements scored through a compare queue,
// then streamed readout with stalls, a pending compare and a reset mid-stream.
module tb_onn_phase_monitor;

  localparam int N = 15;

  logic         sclk = 1'b0;
  logic         re_n = 1'b1;
  logic [N-1:0] osc_in = '0;
  logic         full_tick = 1'b0, drop = 1'b0, state_cheak = 1'b0, phi_to_no = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] state_changed;
  logic         cmp_done, out_valid, out_last;
  logic [3:0]   out_idx, out_phase;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int           off3;
    int           off2;
    bit           drop2;
    logic [N-1:0] exp_sc;
  } vec_t;

  typedef struct {
    logic [3:0] idx;
    logic [3:0] phase;
    logic       last;
  } beat_t;

  vec_t         vecs[10];
  logic [N-1:0] cmp_q[$];
  beat_t        beat_q[$];

`ifdef ONN_PHASE_TOL_EN
  localparam logic [N-1:0] EXP_DRIFT1 = 15'h7FF6;
`else
  localparam logic [N-1:0] EXP_DRIFT1 = 15'h7FFE;
`endif

  onn_phase_monitor dut (
    .sclk          (sclk),
    .re_n          (re_n),
    .osc_in        (osc_in),
    .full_tick     (full_tick),
    .drop          (drop),
    .state_cheak   (state_cheak),
    .phi_to_no     (phi_to_no),
    .state_changed (state_changed),
    .cmp_done      (cmp_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_idx       (out_idx),
    .out_phase     (out_phase),
    .out_last      (out_last)
  );

  always #5 sclk = ~sclk;

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  always @(negedge sclk) begin
    if (re_n && cmp_done) begin
      if (cmp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cmp_unexpected: got cmp_done=1, expected no pulse");
      end else begin
        check("state_changed", 32'(state_changed), 32'(cmp_q.pop_front()));
      end
    end
  end

  task automatic wait_cmp(input string name);
    for (int t = 0; t < 10 && cmp_q.size() != 0; t++) tick;
    check(name, 32'(cmp_q.size()), 32'd0);
    cmp_q.delete();
  endtask

  task automatic run_meas(input vec_t v, input int row);
    full_tick = 1'b1;
    tick;
    tick;
    for (int k = 0; k < 16; k++) begin
      osc_in    = '0;
      osc_in[0] = (k == 0);
      osc_in[2] = (k == v.off2);
      osc_in[3] = (k == v.off3);
      drop      = v.drop2 && (k == v.off2);
      tick;
    end
    osc_in      = '0;
    drop        = 1'b0;
    state_cheak = 1'b1;
    cmp_q.push_back(v.exp_sc);
    tick;
    tick;
    state_cheak = 1'b0;
    full_tick   = 1'b0;
    wait_cmp($sformatf("cmp_row%0d", row));
    tick;
    tick;
  endtask

  task automatic stream_test;
    int    beats;
    bit    stalled;
    beat_t held;
    beat_t e;
    beats   = 0;
    stalled = 1'b0;
    held    = '{4'd0, 4'd0, 1'b0};
    for (int i = 0; i < N; i++) begin
      e.idx   = 4'(i);
      e.phase = (i == 2) ? 4'd7 : (i == 3) ? 4'd12 : 4'd0;
      e.last  = (i == N - 1);
      beat_q.push_back(e);
    end
    phi_to_no = 1'b1;
    out_ready = 1'b0;
    tick;
    for (int c = 0; c < 100 && beats < N; c++) begin
      if (c == 1) phi_to_no = 1'b0;
      if (c == 3) begin
        state_cheak = 1'b1;
        cmp_q.push_back(15'h7FFF);
      end
      if (c == 5) state_cheak = 1'b0;
      out_ready = (c % 2 == 1);
      if (stalled) begin
        check("stall_idx", 32'(out_idx), 32'(held.idx));
        check("stall_phase", 32'(out_phase), 32'(held.phase));
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          check("beat_extra", 32'(out_idx), 32'hFFFF);
        end else begin
          e = beat_q.pop_front();
          check($sformatf("beat%0d_idx", beats), 32'(out_idx), 32'(e.idx));
          check($sformatf("beat%0d_phase", beats), 32'(out_phase), 32'(e.phase));
          check($sformatf("beat%0d_last", beats), 32'(out_last), 32'(e.last));
        end
        beats++;
      end else if (out_valid) begin
        stalled = 1'b1;
        held    = '{out_idx, out_phase, out_last};
      end
      tick;
    end
    out_ready = 1'b0;
    check("stream_beats", 32'(beats), 32'(N));
    check("valid_after_last", 32'(out_valid), 32'd0);
    wait_cmp("cmp_pending");
  endtask

  task automatic reset_stream_test;
    bit hit;
    int late;
    hit  = 1'b0;
    late = 0;
    out_ready = 1'b1;
    phi_to_no = 1'b1;
    tick;
    phi_to_no = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (out_valid && out_idx == 4'd7) hit = 1'b1;
      else tick;
    end
    check("stream2_reach_idx7", 32'(hit), 32'd1);
    re_n = 1'b0;
    #1;
    check("valid_on_reset", 32'(out_valid), 32'd0);
    check("idx_on_reset", 32'(out_idx), 32'd0);
    check("sc_on_reset", 32'(state_changed), 32'h7FFF);
    tick;
    tick;
    re_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (out_valid) late++;
    end
    check("beats_after_reset", 32'(late), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5,  -1, 1'b0, 15'h7FFE};
    vecs[1] = '{5,  -1, 1'b0, 15'h7FF6};
    vecs[2] = '{6,  -1, 1'b0, EXP_DRIFT1};
    vecs[3] = '{15, -1, 1'b0, 15'h7FFE};
    vecs[4] = '{0,  -1, 1'b0, EXP_DRIFT1};
    vecs[5] = '{10,  8, 1'b1, 15'h7FFF};
    vecs[6] = '{10,  4, 1'b0, 15'h7FF6};
    vecs[7] = '{10,  4, 1'b0, 15'h7FF2};
    vecs[8] = '{10,  4, 1'b1, 15'h7FF7};
    vecs[9] = '{12,  7, 1'b0, 15'h7FFE};

    #2;
    re_n = 1'b0;
    tick;
    tick;
    tick;
    check("rst_state_changed", 32'(state_changed), 32'h7FFF);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cmp_done", 32'(cmp_done), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_phase", 32'(out_phase), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    re_n = 1'b1;
    tick;
    tick;
    tick;

    for (int r = 0; r < 10; r++) run_meas(vecs[r], r);

    stream_test();
    tick;
    tick;
    reset_stream_test();

    check("beat_queue_empty", 32'(beat_q.size()), 32'd0);
    check("cmp_queue_empty", 32'(cmp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
